// File: rtl/sprite_compositor.sv
// sprite_compositor: multi-sprite hit test, priority, collision and register bus
module sprite_compositor #(
    parameter int NUM_SPRITES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_active,
    input  logic        vsync,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt,
    output logic        sprite_pixel_on,
    output logic [5:0]  sprite_rgb
);
    localparam int N = NUM_SPRITES;
    localparam logic [N-1:0] ONE = 1;

    logic [3:0]   ctrl_q, ctrl_d;
    logic [N-1:0] status_q, status_d, opq;
    logic [2:0]   sel_q, sel_d;
    logic [26:0]  sh_q [N];
    logic [26:0]  sh_d [N];
    logic [26:0]  act_q [N];
    logic [26:0]  act_d [N];
    logic [63:0]  bmp_q [N];
    logic [63:0]  bmp_d [N];
    logic [9:0]   dx [N];
    logic [9:0]   dy [N];
    logic [9:0]   lim;
    logic         vsync_q, irq_q, rdy_q, pix_on_q;
    logic [5:0]   rgb_q, rgb_d;
    logic [31:0]  dout_q, dout_d, r_attr, r_lo, r_hi;
    logic         we, rd, rise, multi;
    logic [3:0]   wa;
    logic         unused;

    assign unused = ^address[1:0];
    assign we     = data_write_n == 2'b10;
    assign rd     = data_read_n != 2'b11;
    assign wa     = address[5:2];
    assign rise   = vsync & ~vsync_q;
    assign lim    = ctrl_q[1] ? 10'd16 : 10'd8;
    assign multi  = |(opq & (opq - ONE));

    for (genvar k = 0; k < N; k++) begin : g_hit
        assign dx[k]  = pix_x - act_q[k][9:0];
        assign dy[k]  = pix_y - act_q[k][19:10];
        assign opq[k] = ctrl_q[0] & act_q[k][26] & video_active & (dx[k] < lim) & (dy[k] < lim)
                      & bmp_q[k][ctrl_q[1] ? {dy[k][3:1], dx[k][3:1]} : {dy[k][2:0], dx[k][2:0]}];
    end

    // lowest-index opaque sprite supplies the colour
    always_comb begin
        rgb_d = '0;
        for (int i = N - 1; i >= 0; i--)
            if (opq[i]) rgb_d = act_q[i][25:20];
    end

    // register writes, frame commit, collision flags and read mux
    always_comb begin
        ctrl_d   = ctrl_q;
        sel_d    = sel_q;
        sh_d     = sh_q;
        act_d    = act_q;
        bmp_d    = bmp_q;
        status_d = status_q;
        r_attr   = '0;
        r_lo     = '0;
        r_hi     = '0;
        if (rise) act_d = sh_q;
        if (we && wa == 4'h0) ctrl_d = data_in[3:0];
        if (we && wa == 4'h1) status_d = status_q & ~data_in[N-1:0];
        if (we && wa == 4'h2) sel_d = data_in[2:0];
        for (int i = 0; i < N; i++) begin
            if (sel_q == 3'(i)) begin
                r_attr = {sh_q[i][26], 5'b0, sh_q[i][25:0]};
                r_lo   = bmp_q[i][31:0];
                r_hi   = bmp_q[i][63:32];
                if (we && wa == 4'h3) begin
                    sh_d[i] = {data_in[31], data_in[25:0]};
                    if (ctrl_q[3]) act_d[i] = {data_in[31], data_in[25:0]};
                end
                if (we && wa == 4'h4) bmp_d[i][31:0] = data_in;
                if (we && wa == 4'h5) bmp_d[i][63:32] = data_in;
            end
        end
        if (multi) status_d = status_d | opq;
        dout_d = wa == 4'h0 ? {28'b0, ctrl_q} :
                 wa == 4'h1 ? 32'(status_q) :
                 wa == 4'h2 ? {29'b0, sel_q} :
                 wa == 4'h3 ? r_attr :
                 wa == 4'h4 ? r_lo :
                 wa == 4'h5 ? r_hi : 32'b0;
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            status_q <= '0;
            sel_q    <= '0;
            sh_q     <= '{default: '0};
            act_q    <= '{default: '0};
            bmp_q    <= '{default: '0};
            vsync_q  <= 1'b0;
            irq_q    <= 1'b0;
            rdy_q    <= 1'b0;
            dout_q   <= '0;
            pix_on_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            sel_q    <= sel_d;
            sh_q     <= sh_d;
            act_q    <= act_d;
            bmp_q    <= bmp_d;
            vsync_q  <= vsync;
            irq_q    <= ctrl_q[2] & |status_q;
            rdy_q    <= rd;
            dout_q   <= rd ? dout_d : '0;
            pix_on_q <= |opq;
            rgb_q    <= rgb_d;
        end
    end

    assign data_out        = dout_q;
    assign data_ready      = rdy_q;
    assign user_interrupt  = irq_q;
    assign sprite_pixel_on = pix_on_q;
    assign sprite_rgb      = rgb_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed scoreboard bench for sprite_compositor
module tb_sprite_compositor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        video_active = 1'b0, vsync = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11, data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready, user_interrupt, sprite_pixel_on;
    logic [5:0]  sprite_rgb;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          n_assert = 0;
    int          n_fail = 0;

    sprite_compositor #(.NUM_SPRITES(4)) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .vsync(vsync), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt),
        .sprite_pixel_on(sprite_pixel_on), .sprite_rgb(sprite_rgb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", t, obs, e);
        end
    endtask

    function automatic logic [31:0] attr(input int x, input int y, input int c, input bit en);
        return {en, 5'b0, 6'(c), 10'(y), 10'(x)};
    endfunction

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn = 2'b10);
        address = a;
        data_in = d;
        data_write_n = wn;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic rdc(input logic [5:0] a, input logic [31:0] e, input string t);
        address = a;
        data_read_n = 2'b10;
        push({t, "_rdy"}, 32'd1);
        push(t, e);
        tick();
        data_read_n = 2'b11;
        check({31'b0, data_ready});
        check(data_out);
    endtask

    task automatic px(input int x, input int y, input bit on, input logic [5:0] rgb, input string t,
                      input bit va = 1'b1);
        pix_x = 10'(x);
        pix_y = 10'(y);
        video_active = va;
        push(t, {25'b0, on, rgb});
        tick();
        video_active = 1'b0;
        check({25'b0, sprite_pixel_on, sprite_rgb});
    endtask

    task automatic irq_chk(input bit e, input string t);
        push(t, {31'b0, e});
        check({31'b0, user_interrupt});
    endtask

    task automatic vs();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        // reset
        tick();
        tick();
        push("rst_dout", 0);   check(data_out);
        push("rst_rdy", 0);    check({31'b0, data_ready});
        push("rst_irq", 0);    check({31'b0, user_interrupt});
        push("rst_pix", 0);    check({31'b0, sprite_pixel_on});
        push("rst_rgb", 0);    check({26'b0, sprite_rgb});
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 6; a++) rdc(6'(a * 4), 0, $sformatf("rst_reg%0d", a));
        push("rdy_drop", 0);
        tick();
        check({31'b0, data_ready});
        address = 6'h00;
        data_read_n = 2'b10;
        push("hold_rdy1", 1);
        tick();
        check({31'b0, data_ready});
        push("hold_rdy2", 1);
        tick();
        check({31'b0, data_ready});
        data_read_n = 2'b11;
        push("hold_rdy_end", 0);
        tick();
        check({31'b0, data_ready});

        // single sprite
        wr(6'h08, 0);
        wr(6'h10, 32'h1);
        wr(6'h0C, attr(100, 50, 6'h30, 1));
        wr(6'h00, 32'h1);
        rdc(6'h0C, attr(100, 50, 6'h30, 1), "attr_rb");
        px(100, 50, 0, 0, "pre_commit");
        vs();
        px(100, 50, 1, 6'h30, "hit");
        px(101, 50, 0, 0, "miss_x1");
        px(100, 51, 0, 0, "miss_y1");
        px(100, 50, 0, 0, "blank", 1'b0);

        // shadowing and immediate
        wr(6'h0C, attr(200, 50, 6'h30, 1));
        px(100, 50, 1, 6'h30, "shadow_old");
        px(200, 50, 0, 0, "shadow_new_wait");
        vs();
        px(200, 50, 1, 6'h30, "shadow_new");
        px(100, 50, 0, 0, "shadow_old_gone");
        wr(6'h00, 32'h9);
        wr(6'h0C, attr(300, 50, 6'h30, 1));
        px(300, 50, 1, 6'h30, "immediate");

        // scale2x
        wr(6'h00, 32'h3);
        px(300, 50, 1, 6'h30, "sc_00");
        px(301, 50, 1, 6'h30, "sc_10");
        px(300, 51, 1, 6'h30, "sc_01");
        px(301, 51, 1, 6'h30, "sc_11");
        px(302, 50, 0, 0, "sc_20");
        px(300, 52, 0, 0, "sc_02");

        // horizontal wrap
        wr(6'h00, 32'h9);
        wr(6'h0C, attr(1020, 50, 6'h30, 1));
        wr(6'h10, 32'h40);
        px(2, 50, 1, 6'h30, "wrap_hit");
        px(3, 50, 0, 0, "wrap_b7");
        px(1020, 50, 0, 0, "wrap_b0");

        // priority and collision
        wr(6'h00, 32'hD);
        wr(6'h0C, attr(100, 50, 6'h03, 1));
        wr(6'h10, 32'h1);
        wr(6'h08, 2);
        wr(6'h0C, attr(100, 50, 6'h0C, 1));
        wr(6'h10, 32'h1);
        px(100, 50, 1, 6'h03, "prio");
        rdc(6'h04, 32'h5, "coll_status");
        irq_chk(1, "irq_set");
        wr(6'h04, 32'h5);
        tick();
        irq_chk(0, "irq_clr");
        rdc(6'h04, 0, "status_clr");
        px(100, 50, 1, 6'h03, "prio_again");
        tick();
        irq_chk(1, "irq_recur");
        pix_x = 10'd100;
        pix_y = 10'd50;
        video_active = 1'b1;
        wr(6'h04, 32'h5);
        video_active = 1'b0;
        rdc(6'h04, 32'h5, "set_wins");

        // commit coincident with ATTR write
        wr(6'h00, 32'h5);
        wr(6'h08, 0);
        wr(6'h0C, attr(150, 50, 6'h03, 1));
        px(150, 50, 0, 0, "pre_commit2");
        vsync = 1'b1;
        wr(6'h0C, attr(400, 50, 6'h03, 1));
        vsync = 1'b0;
        tick();
        px(150, 50, 1, 6'h03, "commit_pre_write");
        px(400, 50, 0, 0, "commit_new_wait");
        rdc(6'h0C, attr(400, 50, 6'h03, 1), "shadow_holds_new");
        vs();
        px(400, 50, 1, 6'h03, "commit_new");

        // guards
        wr(6'h08, 7);
        wr(6'h0C, attr(5, 5, 1, 1));
        rdc(6'h0C, 0, "sel7_attr");
        rdc(6'h10, 0, "sel7_bmp");
        rdc(6'h08, 7, "sel7_rb");
        wr(6'h00, 32'h0, 2'b00);
        rdc(6'h00, 32'h5, "ctrl_8bit");
        wr(6'h00, 32'h0, 2'b01);
        rdc(6'h00, 32'h5, "ctrl_16bit");
        wr(6'h18, 32'hFFFF_FFFF);
        rdc(6'h18, 0, "unmapped");

        // reset mid-frame
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rdc(6'h00, 0, "mid_rst_ctrl");
        irq_chk(0, "mid_rst_irq");
        rdc(6'h0C, 0, "mid_rst_attr");
        px(400, 50, 0, 0, "mid_rst_pix");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
